// File: rtl/mem_if_sram_responder_if.sv
// Request/grant/rvalid memory bus between a core-side master and a memory
// responder. Request fields are held by the master until granted.
interface mem_if_sram_responder_if #(
  parameter int ADDRESS_SIZE = 64,
  parameter int DATA_WIDTH   = 64
);
  logic [ADDRESS_SIZE-1:0]   address;
  logic [DATA_WIDTH-1:0]     wdata;
  logic                      req;
  logic                      we;
  logic [DATA_WIDTH/8-1:0]   be;
  logic                      gnt;
  logic                      rvalid;
  logic [DATA_WIDTH-1:0]     rdata;

  modport master (
    output address, wdata, req, we, be,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  address, wdata, req, we, be,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/mem_if_sram_responder.sv
// Slave-side responder for the req/gnt/rvalid memory bus, backed by a
// word-addressed SRAM. Grants are throttled by a wait-state counter and an
// external stall; read data returns in order after a fixed pipeline latency.
module mem_if_sram_responder #(
  parameter int ADDRESS_SIZE = 64,
  parameter int DATA_WIDTH   = 64,
  parameter int NUM_WORDS    = 1024,
  parameter int RD_LATENCY   = 2,
  parameter int GNT_DELAY    = 0
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     stall_i,
  mem_if_sram_responder_if.slave   bus
);

  localparam int NUM_BYTES = DATA_WIDTH / 8;
  localparam int OFF       = $clog2(NUM_BYTES);
  localparam int IDX_W     = $clog2(NUM_WORDS);

  localparam logic [3:0] WAIT_TARGET = 4'(GNT_DELAY);

  // Wait-state view of the counter: WAIT until enough cycles have elapsed.
  localparam logic [0:0] ST_WAIT  = 1'b0;
  localparam logic [0:0] ST_READY = 1'b1;

  logic [3:0]            wait_cnt;
  logic [0:0]            state;
  logic [IDX_W-1:0]      word_idx;
  logic                  rd_fire;
  logic                  wr_fire;
  logic                  unused_addr_bits;

  logic [DATA_WIDTH-1:0] mem [NUM_WORDS];

  logic [RD_LATENCY-1:0] pipe_valid;
  logic [DATA_WIDTH-1:0] pipe_data [RD_LATENCY];

  // Offset bits and bits above the SRAM depth are ignored, so addresses wrap.
  assign word_idx         = bus.address[OFF +: IDX_W];
  assign unused_addr_bits = ^bus.address;

  assign state   = (wait_cnt >= WAIT_TARGET) ? ST_READY : ST_WAIT;
  assign bus.gnt = rst_ni & bus.req & ~stall_i & (state == ST_READY);
  assign rd_fire = bus.gnt & ~bus.we;
  assign wr_fire = bus.gnt &  bus.we;

  // Wait counter: counts held, unstalled, ungranted request cycles.
  always_ff @(posedge clk_i) begin
    // NOTE: all clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    if (!rst_ni) begin
      wait_cnt <= '0;
    end else if (bus.gnt || !bus.req) begin
      wait_cnt <= '0;
    end else if (!stall_i && wait_cnt != 4'hF) begin
      wait_cnt <= wait_cnt + 4'd1;
    end
  end

  // Byte-enabled SRAM write at the end of the grant cycle.
  always_ff @(posedge clk_i) begin
    // NOTE: the SRAM array has no reset; contents survive rst_ni so data
    // written before a reset reads back afterwards, and it maps onto macros.
    if (wr_fire) begin
      for (int b = 0; b < NUM_BYTES; b++) begin
        if (bus.be[b]) begin
          mem[word_idx][8*b +: 8] <= bus.wdata[8*b +: 8];
        end
      end
    end
  end

  // Read valid shift chain; cleared on reset so in-flight reads are dropped.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      pipe_valid <= '0;
    end else begin
      pipe_valid[0] <= rd_fire;
      for (int i = 1; i < RD_LATENCY; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
      end
    end
  end

  // Read data shift chain; the word is sampled from the SRAM in the grant cycle.
  always_ff @(posedge clk_i) begin
    if (rd_fire) begin
      pipe_data[0] <= mem[word_idx];
    end
    for (int i = 1; i < RD_LATENCY; i++) begin
      pipe_data[i] <= pipe_data[i-1];
    end
  end

  assign bus.rvalid = pipe_valid[RD_LATENCY-1];
  assign bus.rdata  = bus.rvalid ? pipe_data[RD_LATENCY-1] : '0;

endmodule

// File: tb/tb_mem_if_sram_responder.sv
// Self-checking bench for mem_if_sram_responder. A main instance (no wait
// states) is checked against a scoreboard of expected read responses; two
// more instances with GNT_DELAY=3 and GNT_DELAY=2 exercise grant timing.
module tb_mem_if_sram_responder;

  localparam int NW  = 64;
  localparam int LAT = 2;

  typedef struct {
    logic [63:0] data;
    int          cyc;
  } exp_t;

  logic clk;
  logic rst_ni;
  logic stall0, stall2, stall3;

  mem_if_sram_responder_if #(.ADDRESS_SIZE(64), .DATA_WIDTH(64)) m0 ();
  mem_if_sram_responder_if #(.ADDRESS_SIZE(64), .DATA_WIDTH(64)) m2 ();
  mem_if_sram_responder_if #(.ADDRESS_SIZE(64), .DATA_WIDTH(64)) m3 ();

  mem_if_sram_responder #(.ADDRESS_SIZE(64), .DATA_WIDTH(64), .NUM_WORDS(NW),
                          .RD_LATENCY(LAT), .GNT_DELAY(0)) dut0 (
    .clk_i(clk), .rst_ni(rst_ni), .stall_i(stall0), .bus(m0));
  mem_if_sram_responder #(.ADDRESS_SIZE(64), .DATA_WIDTH(64), .NUM_WORDS(NW),
                          .RD_LATENCY(LAT), .GNT_DELAY(2)) dut2 (
    .clk_i(clk), .rst_ni(rst_ni), .stall_i(stall2), .bus(m2));
  mem_if_sram_responder #(.ADDRESS_SIZE(64), .DATA_WIDTH(64), .NUM_WORDS(NW),
                          .RD_LATENCY(LAT), .GNT_DELAY(3)) dut3 (
    .clk_i(clk), .rst_ni(rst_ni), .stall_i(stall3), .bus(m3));

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc      = 0;
  int          rv_count = 0;
  int          last_wait;
  exp_t        sb[$];
  logic [63:0] model [NW];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic int widx(input logic [63:0] a);
    return int'(a[3 +: 6]);
  endfunction

  // Response monitor: every rvalid must match the oldest expected read.
  always @(negedge clk) begin
    if (m0.rvalid === 1'b1) begin
      rv_count++;
      if (sb.size() == 0) begin
        check("rvalid_unexpected", 1'b1, 1'b0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("rdata", m0.rdata, e.data);
        check("rvalid_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  // Issue one request on the main bus, held until granted; called at posedge+1.
  task automatic do_req(input logic [63:0] a, input logic w, input logic [63:0] d,
                        input logic [7:0] be);
    int waited = 0;
    bit done = 1'b0;
    m0.address = a;
    m0.we      = w;
    m0.wdata   = d;
    m0.be      = be;
    m0.req     = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (m0.gnt === 1'b1) begin
        done = 1'b1;
        if (w) begin
          for (int b = 0; b < 8; b++)
            if (be[b]) model[widx(a)][8*b +: 8] = d[8*b +: 8];
        end else begin
          sb.push_back('{data: model[widx(a)], cyc: cyc + LAT});
        end
      end else begin
        waited++;
        if (waited > 40) begin
          check("gnt_timeout", 1'b0, 1'b1);
          done = 1'b1;
        end
      end
      @(posedge clk); #1;
    end
    last_wait = waited;
  endtask

  task automatic idle0();
    m0.req = 1'b0;
    m0.we  = 1'b0;
    m0.be  = '0;
  endtask

  // Wait for all outstanding reads to return, with a cycle budget.
  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(posedge clk);
      n++;
    end
    check("drain_outstanding", 64'(sb.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    rst_ni = 1'b0;
    stall0 = 1'b0; stall2 = 1'b0; stall3 = 1'b0;
    m0.address = '0; m0.wdata = '0; m0.we = 1'b0; m0.be = '0; m0.req = 1'b1;
    m2.address = '0; m2.wdata = '0; m2.we = 1'b1; m2.be = '0; m2.req = 1'b0;
    m3.address = '0; m3.wdata = '0; m3.we = 1'b1; m3.be = '0; m3.req = 1'b0;

    // Reset state: a request raised during reset is not granted.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_gnt", m0.gnt, 1'b0);
    check("reset_rvalid", m0.rvalid, 1'b0);
    check("reset_rdata", m0.rdata, 64'h0);
    @(posedge clk); #1;
    m0.req = 1'b0;
    rst_ni = 1'b1;
    @(posedge clk); #1;

    // Write then read back, read issued the cycle after the write.
    do_req(64'h40, 1'b1, 64'h1122334455667788, 8'hFF);
    do_req(64'h40, 1'b0, 64'h0, 8'h00);
    idle0();
    drain();

    // Byte enables, including an all-zero enable write.
    do_req(64'h80, 1'b1, 64'hAAAAAAAAAAAAAAAA, 8'hFF);
    do_req(64'h80, 1'b1, 64'h00000000000000BB, 8'h01);
    do_req(64'h80, 1'b0, 64'h0, 8'h00);
    do_req(64'h80, 1'b1, 64'h5555555555555555, 8'h00);
    do_req(64'h80, 1'b0, 64'h0, 8'h00);
    idle0();
    drain();

    // Stall on the zero-wait instance: held read granted only when stall drops.
    stall0 = 1'b1;
    m0.address = 64'h40; m0.we = 1'b0; m0.req = 1'b1;
    for (int k = 0; k <= 5; k++) begin
      @(negedge clk);
      check($sformatf("stall_gnt_c%0d", k), m0.gnt, 1'(k == 5));
      if (m0.gnt === 1'b1) sb.push_back('{data: model[widx(64'h40)], cyc: cyc + LAT});
      @(posedge clk); #1;
      if (k == 4) stall0 = 1'b0;
    end
    idle0();
    drain();

    // GNT_DELAY=3: request held continuously, grants in cycles 3 and 7.
    m3.req = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check($sformatf("wait3_gnt_c%0d", k), m3.gnt, 1'((k == 3) || (k == 7)));
      @(posedge clk); #1;
    end
    m3.req = 1'b0;

    // GNT_DELAY=2 with a one-cycle stall in cycle 1: counter holds, grant in cycle 3.
    m2.req = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("wait2_stall_gnt_c%0d", k), m2.gnt, 1'(k == 3));
      @(posedge clk); #1;
      stall2 = (k == 0);
      if (k == 3) m2.req = 1'b0;
    end
    stall2 = 1'b0;

    // Streaming: 8 back-to-back reads, each granted without waiting.
    for (int i = 0; i < 8; i++)
      do_req(64'(8 * i), 1'b1, 64'hC0DE_0000_0000_0000 | 64'(i * 17), 8'hFF);
    for (int i = 0; i < 8; i++) begin
      do_req(64'(8 * i), 1'b0, 64'h0, 8'h00);
      check($sformatf("stream_gnt_wait_%0d", i), 64'(last_wait), 64'd0);
    end
    idle0();
    drain();
    @(negedge clk);
    check("idle_rdata_zero", m0.rdata, 64'h0);
    @(posedge clk); #1;

    // Address wrap: NUM_WORDS*8 aliases to word 0.
    do_req(64'(NW * 8), 1'b1, 64'hDEADBEEF_CAFEF00D, 8'hFF);
    do_req(64'h0, 1'b0, 64'h0, 8'h00);
    idle0();
    drain();

    // Reset mid-flight: two reads granted, reset raised right after the second.
    m0.address = 64'h40; m0.we = 1'b0; m0.req = 1'b1;
    @(negedge clk);
    check("midrst_rd1_gnt", m0.gnt, 1'b1);
    @(posedge clk); #1;
    m0.address = 64'h80;
    @(negedge clk);
    check("midrst_rd2_gnt", m0.gnt, 1'b1);
    begin
      int rv_before;
      rv_before = rv_count;
      rst_ni = 1'b0;
      m0.req = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_ni = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      check("midrst_no_rvalid", 64'(rv_count - rv_before), 64'd0);
    end

    // Data written before reset is retained.
    do_req(64'h40, 1'b0, 64'h0, 8'h00);
    do_req(64'h80, 1'b0, 64'h0, 8'h00);
    idle0();
    drain();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_if_sram_responder.md
Name: mem_if_sram_responder

Overview:
- Slave-side responder for the core's generic req/gnt/rvalid memory interface, backed by a word-addressed SRAM model.
- Accepts one request per granted cycle and applies byte-enabled writes.
- Returns read data in order after a fixed pipeline latency.
- Grant timing is configurable through wait states and an external stall, so masters are exercised against non-ideal memories.
- Used in core testbenches and as a simple on-chip scratchpad.

Parameters:
- ADDRESS_SIZE, 64, width of the byte address.
- DATA_WIDTH, 64, data width in bits; must be a multiple of 8 and a power of two.
- NUM_WORDS, 1024, SRAM depth in words; power of two.
- RD_LATENCY, 2, cycles from read grant to rvalid; range 1..8.
- GNT_DELAY, 0, minimum wait-state cycles a request is held before it is granted; range 0..15.

Ports:
- clk_i  in  1  clock; all logic is on the rising edge.
- rst_ni  in  1  reset, synchronous, active-low.
- address_i  in  ADDRESS_SIZE  byte address of the request.
- data_wdata_i  in  DATA_WIDTH  write data.
- data_req_i  in  1  request valid.
- data_we_i  in  1  1 = write, 0 = read.
- data_be_i  in  DATA_WIDTH/8  byte enables for writes.
- data_gnt_o  out  1  request accepted this cycle.
- data_rvalid_o  out  1  read data valid.
- data_rdata_o  out  DATA_WIDTH  read data.
- stall_i  in  1  bench/system stall; when high, no grant is given.

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_ni is synchronous and active-low, sampled on the rising edge.
- Reset values:
  - data_gnt_o = 0 while rst_ni is low.
  - data_rvalid_o = 0; data_rdata_o = 0.
  - Wait counter = 0; all read-pipeline valid bits = 0.
  - SRAM contents are not reset.
- Word index: address_i[OFF +: log2(NUM_WORDS)], where OFF = log2(DATA_WIDTH/8). Lower offset bits and upper bits are ignored, so addresses wrap modulo NUM_WORDS*DATA_WIDTH/8 bytes.
- Grant: data_gnt_o is combinational and equals data_req_i & ~stall_i & (wait_cnt >= GNT_DELAY). With GNT_DELAY=0, a request is granted in the same cycle it is raised.
- Wait counter (4 bits, saturating at 15):
  - req=1, no grant, stall_i=0: increment.
  - Grant: clear to 0 at the next edge.
  - req=0: clear to 0.
  - stall_i=1: hold its value.
- Master protocol: the master holds the request and all request fields stable until granted. The responder must not depend on stability after the grant.
- Write (granted, we=1):
  - At the end of the grant cycle, each byte b of the addressed word with be[b]=1 is updated; all other bytes are unchanged.
  - be=0 performs no update but the request is still granted.
  - No rvalid is produced for writes.
- Read (granted, we=0):
  - The word is read from the SRAM in the grant cycle, so it reflects every write granted in earlier cycles.
  - The word and a valid bit enter a RD_LATENCY-deep shift pipeline.
  - data_rvalid_o=1 exactly RD_LATENCY cycles after the grant cycle (grant at edge t makes rvalid high in cycle t+RD_LATENCY), for one cycle per read.
  - data_rdata_o = the pipelined word while rvalid=1, and 0 otherwise.
- Ordering and throughput:
  - Responses return in grant order.
  - With GNT_DELAY=0 and stall_i=0, back-to-back reads give one grant per cycle and one rvalid per cycle, with no bubbles.
  - At most RD_LATENCY reads are in flight; there is no response backpressure.
- Read-after-write: a read granted in the cycle after a write to the same word returns the new data.
- Reset mid-operation: in-flight reads are discarded and no rvalid is produced for them. SRAM contents written before reset are retained.
- Wait-state FSM view (implemented as the counter):
  - WAIT: req=1 and wait_cnt < GNT_DELAY.
  - READY: wait_cnt >= GNT_DELAY; grants if ~stall_i.
  - Any grant or req drop returns to the initial state with the counter at 0.

Test Plan:
1. Write then read back (RD_LATENCY=2, GNT_DELAY=0): write 0x1122334455667788 to addr 0x40 with be=0xFF; the read of addr 0x40 granted at cycle t returns rvalid at t+2 with rdata=0x1122334455667788.
2. Byte enables: write 0xAAAAAAAAAAAAAAAA, then write 0x00000000000000BB with be=0x01; the read returns 0xAAAAAAAAAAAAAABB. A write with be=0x00 leaves the word unchanged.
3. Wait states (GNT_DELAY=3): hold req from cycle 0; gnt=1 in cycle 3 only. The next request, raised in cycle 4, is granted in cycle 7.
4. Stall: stall_i=1 for cycles 0-4 with req held and GNT_DELAY=0; gnt stays 0 and is 1 in cycle 5. Counter hold is verified with GNT_DELAY=2 and a stall pulse mid-wait.
5. Streaming plus wrap: 8 back-to-back reads of addresses 0x0, 0x8, ... 0x38 give 8 consecutive rvalids in order. A write to addr NUM_WORDS*8 aliases to word 0.
6. Reset mid-flight: grant 2 reads, assert rst_ni=0 one cycle later; rvalid never rises for them. After reset, data written before reset reads back intact.
